pipe_stall_ctrl: RTL



---
 rtl/pipe_stall_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage WISC core: data-hazard bubbles,
// branch NOP window, memory freeze/resume and halt. Optional perf counters under STALL_PERF_CNT_EN.
module pipe_stall_ctrl #(
  parameter int BR_STALL = 2,
  parameter int CNT_W    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_haz_s2,
  input  logic       data_haz_s1,
  input  logic       branch_haz,
  input  logic       mem_busy,
  input  logic       halt_id,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       pipe_freeze,
  output logic       halted,
`ifdef STALL_PERF_CNT_EN
  output logic [15:0] stall_cycles,
  output logic [15:0] br_cycles,
`endif
  output logic [2:0] busy_state
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    BR_WAIT  = 3'd1,
    MEM_WAIT = 3'd2,
    HALTED   = 3'd3
  } state_e;

  localparam logic [CNT_W-1:0] BR_INIT = CNT_W'(BR_STALL - 1);

  state_e           state_q, state_d;
  logic             ret_br_q, ret_br_d;   // 1: resume into BR_WAIT after freeze
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    ret_br_d    = ret_br_q;
    cnt_d       = cnt_q;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    halted      = 1'b0;
    case (state_q)
      RUN: begin
        if (halt_id) begin
          pc_we   = 1'b0;
          ifid_we = 1'b0;
          state_d = HALTED;
        end else if (mem_busy) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          pipe_freeze = 1'b1;
          ret_br_d    = 1'b0;
          state_d     = MEM_WAIT;
        end else if (data_haz_s2 || data_haz_s1) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_bubble = 1'b1;
        end else if (branch_haz) begin
          pc_we      = 1'b0;
          ifid_flush = 1'b1;
          cnt_d      = BR_INIT;
          state_d    = (BR_STALL == 1) ? RUN : BR_WAIT;
        end
      end
      BR_WAIT: begin
        // ID holds NOPs here, so hazard and branch flags are don't-care
        if (mem_busy) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          pipe_freeze = 1'b1;
          ret_br_d    = 1'b1;
          state_d     = MEM_WAIT;
        end else begin
          ifid_flush = 1'b1;
          if (cnt_q != '0) begin
            pc_we = 1'b0;
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = RUN;
          end
        end
      end
      MEM_WAIT: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        pipe_freeze = 1'b1;
        if (!mem_busy) state_d = ret_br_q ? BR_WAIT : RUN;
      end
      HALTED: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        pipe_freeze = 1'b1;
        halted      = 1'b1;
      end
      default: state_d = RUN;
    endcase
    if (rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      pipe_freeze = 1'b0;
      halted      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      ret_br_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ret_br_q <= ret_br_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy_state = state_q;

`ifdef STALL_PERF_CNT_EN
  logic [15:0] stall_q, br_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      br_q    <= '0;
    end else begin
      if (!pc_we && state_q != HALTED && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (state_q == BR_WAIT && br_q != 16'hFFFF) br_q <= br_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign br_cycles    = br_q;
`endif

endmodule
